// File: rtl/seg7_pkg.sv
// Shared constants and glyph table for the seven-segment display blocks.
// Patterns are active-low, bit order {g,f,e,d,c,b,a}.
package seg7_pkg;

  localparam int NUM_DIGITS = 8;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_MINUS = 7'h3F;

  // 0-9 are the usual digits; 10-15 show A,b,C,d,E,F so an illegal BCD
  // value is still visible on the display.
  function automatic logic [6:0] hex_glyph(input logic [3:0] v);
    logic [6:0] g;
    case (v)
      4'h0:    g = 7'h40;
      4'h1:    g = 7'h79;
      4'h2:    g = 7'h24;
      4'h3:    g = 7'h30;
      4'h4:    g = 7'h19;
      4'h5:    g = 7'h12;
      4'h6:    g = 7'h02;
      4'h7:    g = 7'h78;
      4'h8:    g = 7'h00;
      4'h9:    g = 7'h10;
      4'hA:    g = 7'h08;
      4'hB:    g = 7'h03;
      4'hC:    g = 7'h46;
      4'hD:    g = 7'h21;
      4'hE:    g = 7'h06;
      default: g = 7'h0E;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/seg7_scan_if.sv
// Digit/control inputs from the BCD converter and the display pins.
// load is a one-cycle strobe (no ready: the scanner always accepts it and a
// second load before commit simply replaces the pending value).
interface seg7_scan_if;
  import seg7_pkg::*;

  logic [3:0]            d0;
  logic [3:0]            d1;
  logic [3:0]            d2;
  logic [3:0]            d3;
  logic [3:0]            d4;
  logic                  neg;
  logic                  load;
  logic                  en;
  logic [NUM_DIGITS-1:0] an;
  logic [6:0]            seg;
  logic                  dp;

  modport master (
    output d0, d1, d2, d3, d4, neg, load, en,
    input  an, seg, dp
  );

  modport slave (
    input  d0, d1, d2, d3, d4, neg, load, en,
    output an, seg, dp
  );

endinterface

// File: rtl/seg7_decode.sv
// Combinational 4-bit value to active-low seven-segment pattern, with a
// blank override.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] val,
  input  logic       blank,
  output logic [6:0] seg
);

  // Blank wins over the value.
  always_comb begin
    seg = blank ? SEG_BLANK : hex_glyph(val);
  end

endmodule

// File: rtl/seg7_scan.sv
// Time-multiplexed 8-digit common-anode seven-segment scanner.
// Five BCD digits plus sign are double-buffered (pending -> shadow) and the
// shadow copy only changes on a slot boundary.
// Optional feature: define SEG7_LZB_EN for leading-zero blanking of slots 4..1.
module seg7_scan
  import seg7_pkg::*;
#(
  parameter int CLK_HZ     = 100_000_000,
  parameter int REFRESH_HZ = 1000
) (
  input  logic       clk,
  input  logic       reset,
  seg7_scan_if.slave bus
);

  // Clocks per digit slot; must be at least 2.
  localparam int DIV = CLK_HZ / (REFRESH_HZ * NUM_DIGITS);
  localparam int CW  = (DIV > 2) ? $clog2(DIV) : 1;

  logic [CW-1:0]         pre;
  logic                  tick;
  logic [2:0]            idx;

  logic [4:0][3:0]       in_d;
  logic [4:0][3:0]       pend_d;
  logic [4:0][3:0]       shad_d;
  logic                  pend_neg;
  logic                  shad_neg;
  logic                  pend_flag;

  logic [4:0]            lz_blank;
  logic [3:0]            dig_val;
  logic                  dig_blank;
  logic                  minus_on;
  logic [6:0]            dec_seg;
  logic [6:0]            glyph;

  logic [NUM_DIGITS-1:0] an_q;
  logic [6:0]            seg_q;

  assign tick = (pre == CW'(DIV - 1));
  assign in_d = {bus.d4, bus.d3, bus.d2, bus.d1, bus.d0};

  // Slot prescaler and scan index; idx wraps naturally at 8.
  always_ff @(posedge clk) begin
    if (reset) begin
      pre <= '0;
      idx <= '0;
    end else if (tick) begin
      pre <= '0;
      idx <= idx + 3'd1;
    end else begin
      pre <= pre + 1'b1;
    end
  end

  // Double buffer: commit uses the pending value from before this edge, so a
  // load on a tick cycle lands in pending and waits for the next tick.
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_d    <= '0;
      shad_d    <= '0;
      pend_neg  <= 1'b0;
      shad_neg  <= 1'b0;
      pend_flag <= 1'b0;
    end else begin
      if (tick && pend_flag) begin
        shad_d   <= pend_d;
        shad_neg <= pend_neg;
      end
      if (bus.load) begin
        pend_d   <= in_d;
        pend_neg <= bus.neg;
      end
      if (bus.load) begin
        pend_flag <= 1'b1;
      end else if (tick) begin
        pend_flag <= 1'b0;
      end
    end
  end

`ifdef SEG7_LZB_EN
  logic zero_above;

  // Slot k (4..1) is blank when it and every higher digit are zero; D0 stays.
  always_comb begin
    lz_blank   = '0;
    zero_above = 1'b1;
    for (int k = 4; k >= 1; k--) begin
      zero_above  = zero_above && (shad_d[k] == 4'd0);
      lz_blank[k] = zero_above;
    end
  end
`else
  // Without blanking every digit slot shows its glyph.
  always_comb begin
    lz_blank = '0;
  end
`endif

  // Select what the current slot shows: a digit, the sign, or nothing.
  always_comb begin
    dig_val   = 4'd0;
    dig_blank = 1'b1;
    minus_on  = 1'b0;
    case (idx)
      3'd0: begin dig_val = shad_d[0]; dig_blank = lz_blank[0]; end
      3'd1: begin dig_val = shad_d[1]; dig_blank = lz_blank[1]; end
      3'd2: begin dig_val = shad_d[2]; dig_blank = lz_blank[2]; end
      3'd3: begin dig_val = shad_d[3]; dig_blank = lz_blank[3]; end
      3'd4: begin dig_val = shad_d[4]; dig_blank = lz_blank[4]; end
      3'd5: minus_on = shad_neg;
      default: ;
    endcase
  end

  seg7_decode u_decode (
    .val   (dig_val),
    .blank (dig_blank),
    .seg   (dec_seg)
  );

  assign glyph = minus_on ? SEG_MINUS : dec_seg;

  // Registered pins: one clock behind idx and en.
  always_ff @(posedge clk) begin
    if (reset) begin
      an_q  <= '1;
      seg_q <= SEG_BLANK;
    end else if (bus.en) begin
      an_q  <= ~(NUM_DIGITS'(1) << idx);
      seg_q <= glyph;
    end else begin
      an_q  <= '1;
      seg_q <= SEG_BLANK;
    end
  end

  assign bus.an  = an_q;
  assign bus.seg = seg_q;
  assign bus.dp  = 1'b1;

endmodule

// File: tb/tb_seg7_scan.sv
// Bench for seg7_scan at CLK_HZ=800, REFRESH_HZ=10 (10 clocks per slot).
module tb_seg7_scan;

  localparam int DIV = 10;

  logic clk;
  logic reset;

  seg7_scan_if bus();

  seg7_scan #(.CLK_HZ(800), .REFRESH_HZ(10)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- counters / check ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Active-low glyphs for values 0..15.
  logic [6:0] glyph_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  int         m_cyc = 0;        // clocks since reset release
  logic [3:0] m_pend [5];
  logic [3:0] m_shad [5];
  logic       m_pneg, m_sneg, m_pflag;
  logic [7:0] exp_an;
  logic [6:0] exp_seg;
  bit         model_valid = 0;

  // Outputs follow from elapsed time: slot = (cycles / DIV) mod 8.
  initial begin
    forever begin
      int  slot;
      bit  blank;
      @(posedge clk);
      if (reset) begin
        m_cyc = 0;
        for (int i = 0; i < 5; i++) begin m_pend[i] = 0; m_shad[i] = 0; end
        m_pneg = 0; m_sneg = 0; m_pflag = 0;
        exp_an = 8'hFF; exp_seg = 7'h7F;
        model_valid = 1;
      end else begin
        slot = (m_cyc / DIV) % 8;
        if (!bus.en) begin
          exp_an = 8'hFF; exp_seg = 7'h7F;
        end else begin
          exp_an = ~(8'd1 << slot);
          if (slot < 5) begin
            blank = 0;
`ifdef SEG7_LZB_EN
            if (slot >= 1) begin
              blank = 1;
              for (int k = slot; k <= 4; k++) if (m_shad[k] != 0) blank = 0;
            end
`endif
            exp_seg = blank ? 7'h7F : glyph_tab[m_shad[slot]];
          end else if (slot == 5 && m_sneg) begin
            exp_seg = 7'h3F;
          end else begin
            exp_seg = 7'h7F;
          end
        end
        if ((m_cyc % DIV) == DIV - 1 && m_pflag) begin
          for (int i = 0; i < 5; i++) m_shad[i] = m_pend[i];
          m_sneg = m_pneg; m_pflag = 0;
        end
        if (bus.load) begin
          m_pend[0] = bus.d0; m_pend[1] = bus.d1; m_pend[2] = bus.d2;
          m_pend[3] = bus.d3; m_pend[4] = bus.d4;
          m_pneg = bus.neg; m_pflag = 1;
        end
        m_cyc++;
      end
    end
  end

  // Compare process: every cycle once the model has seen reset.
  initial begin
    forever begin
      @(negedge clk);
      if (model_valid) begin
        check("cyc_an",  bus.an, exp_an);
        check("cyc_seg", {1'b0, bus.seg}, {1'b0, exp_seg});
        check("cyc_dp",  {7'd0, bus.dp}, 8'd1);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_cyc(input int c);
    int guard = 0;
    while (m_cyc != c && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    if (m_cyc != c) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_cyc: reached %0d wanted %0d", m_cyc, c);
    end
  endtask

  task automatic load_digits(input logic [3:0] a4, input logic [3:0] a3, input logic [3:0] a2,
                             input logic [3:0] a1, input logic [3:0] a0, input logic s);
    bus.d4 = a4; bus.d3 = a3; bus.d2 = a2; bus.d1 = a1; bus.d0 = a0;
    bus.neg = s; bus.load = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
  endtask

  task automatic pin(input string name, input logic [7:0] a, input logic [6:0] s);
    check({name, "_an"}, bus.an, a);
    check({name, "_seg"}, {1'b0, bus.seg}, {1'b0, s});
  endtask

  localparam logic [6:0] LZ_SEG =
`ifdef SEG7_LZB_EN
    7'h7F;
`else
    7'h40;
`endif

  // ---------------- directed + random stimulus ----------------
  initial begin
    reset = 1'b1;
    bus.en = 1'b1; bus.load = 1'b0; bus.neg = 1'b0;
    bus.d0 = 0; bus.d1 = 0; bus.d2 = 0; bus.d3 = 0; bus.d4 = 0;
    repeat (3) @(negedge clk);
    pin("reset", 8'hFF, 7'h7F);
    reset = 1'b0;

    wait_cyc(1);   pin("first_slot", 8'hFE, 7'h40);
    wait_cyc(10);  pin("slot0_end", 8'hFE, 7'h40);
    wait_cyc(11);  pin("slot1_start", 8'hFD, 7'h40);

    // Mid-slot load of 1,2,3,4,5 with sign.
    wait_cyc(23);  load_digits(4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 1'b1);
    wait_cyc(29);  pin("before_commit", 8'hFB, 7'h40);
    wait_cyc(31);  pin("slot3_new", 8'hF7, 7'h24);
    wait_cyc(41);  pin("slot4_new", 8'hEF, 7'h79);
    wait_cyc(51);  pin("slot5_minus", 8'hDF, 7'h3F);
    wait_cyc(61);  pin("slot6_blank", 8'hBF, 7'h7F);
    wait_cyc(81);  pin("wrap_slot0", 8'hFE, 7'h12);

    // Load on the tick cycle: committed one slot later.
    wait_cyc(89);  load_digits(4'd9, 4'd8, 4'd7, 4'd6, 4'd5, 1'b0);
    wait_cyc(91);  pin("tick_load_old", 8'hFD, 7'h19);
    wait_cyc(101); pin("tick_load_new", 8'hFB, 7'h78);

    // Leading zeros: D = 0,0,0,4,2.
    wait_cyc(163); load_digits(4'd0, 4'd0, 4'd0, 4'd4, 4'd2, 1'b0);
    wait_cyc(171); pin("lz_slot1", 8'hFD, 7'h19);
    wait_cyc(191); pin("lz_slot3", 8'hF7, LZ_SEG);
    wait_cyc(201); pin("lz_slot4", 8'hEF, LZ_SEG);
    wait_cyc(211); pin("lz_sign_off", 8'hDF, 7'h7F);
    wait_cyc(241); pin("lz_slot0", 8'hFE, 7'h24);

    // Blank for 30 clocks, scanning continues.
    wait_cyc(250); bus.en = 1'b0;
    wait_cyc(251); pin("en_off", 8'hFF, 7'h7F);
    wait_cyc(280); pin("en_off_end", 8'hFF, 7'h7F); bus.en = 1'b1;
    wait_cyc(281); check("en_on_an", bus.an, 8'hEF);

    // Illegal BCD digit shows as hex C.
    wait_cyc(283); load_digits(4'd0, 4'd3, 4'd2, 4'd1, 4'hC, 1'b1);
    wait_cyc(321); pin("hex_c", 8'hFE, 7'h46);

    // Pending load lost to a mid-slot reset.
    wait_cyc(323); load_digits(4'd0, 4'd0, 4'd0, 4'd0, 4'd7, 1'b0);
    wait_cyc(325); reset = 1'b1;
    repeat (3) @(negedge clk);
    pin("mid_reset", 8'hFF, 7'h7F);
    reset = 1'b0;
    wait_cyc(1);   pin("post_reset", 8'hFE, 7'h40);
    wait_cyc(81);  pin("pending_lost", 8'hFE, 7'h40);

    // Random phase, checked every cycle by the compare process.
    for (int n = 0; n < 3000; n++) begin
      bus.d0 = 4'($urandom_range(0, 15));
      bus.d1 = 4'($urandom_range(0, 15));
      bus.d2 = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      bus.d3 = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      bus.d4 = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(0, 9));
      bus.neg  = 1'($urandom_range(0, 1));
      bus.load = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 49) == 0) bus.en = ~bus.en;
      reset = ($urandom_range(0, 599) == 0);
      @(negedge clk);
    end
    reset = 1'b0; bus.load = 1'b0; bus.en = 1'b1;
    repeat (100) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
